// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and geometry helpers
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sw, input int unsigned bp);
    return act + fp + sw + bp;
  endfunction

  // Sync region is [sync_first, sync_end) in pixels or lines.
  function automatic int unsigned sync_first(input int unsigned act, input int unsigned fp);
    return act + fp;
  endfunction

  function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                           input int unsigned sw);
    return act + fp + sw;
  endfunction

  function automatic bit fits_width(input int unsigned last, input int unsigned w);
    return (w >= 32) || ((last >> w) == 0);
  endfunction

  localparam int unsigned DEF_H_TOTAL  = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL  = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int unsigned DEF_HS_FIRST = sync_first(DEF_H_ACTIVE, DEF_H_FP);
  localparam int unsigned DEF_HS_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int unsigned DEF_VS_FIRST = sync_first(DEF_V_ACTIVE, DEF_V_FP);
  localparam int unsigned DEF_VS_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_pix_en.sv
// rtl/vga_pix_en.sv - clk-to-pixel divider producing a one-clk pix_en strobe
module vga_pix_en
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pix_en
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so pix_en follows en.
  assign pix_en = en & ~rst & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          blank,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_geometry
    $error("vga_timing_gen: every active/porch/sync parameter must be nonzero");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (!fits_width(H_TOTAL - 1, CW) || !fits_width(V_TOTAL - 1, CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 or V_TOTAL-1");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] HS_STOP  = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] VS_FIRST = CW'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] VS_STOP  = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic          pix_en_w;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          active_q, active_d, blank_q;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          line_q, line_d, frame_q, frame_d;

  vga_pix_en #(.CLK_DIV(CLK_DIV)) u_pix_en (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .pix_en (pix_en_w)
  );

  // Decode is taken from the next position so every registered output
  // describes the same pixel as x/y.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_w) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
    active_d = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d  = ((h_d >= HS_FIRST) && (h_d < HS_STOP)) ? HS_POL : ~HS_POL;
    vsync_d  = ((v_d >= VS_FIRST) && (v_d < VS_STOP)) ? VS_POL : ~VS_POL;
    line_d   = pix_en_w && (h_d == '0);
    frame_d  = line_d && (v_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q      <= '0;
      v_q      <= '0;
      active_q <= 1'b1;
      blank_q  <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      active_q <= active_d;
      blank_q  <= ~active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign pix_en      = pix_en_w;
  assign x           = h_q;
  assign y           = v_q;
  assign active      = active_q;
  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench against an arithmetic raster model
module tb_vga_timing_gen;

  localparam int ND = 4;
  // 0: default 640x480 DIV2, 1: tiny DIV1, 2: tiny inverted sync, 3: medium DIV3 hs high
  localparam int HA  [ND] = '{640, 4, 4, 20};
  localparam int HF  [ND] = '{16, 1, 1, 3};
  localparam int HSW [ND] = '{96, 2, 2, 5};
  localparam int HB  [ND] = '{48, 1, 1, 4};
  localparam int VA  [ND] = '{480, 3, 3, 6};
  localparam int VF  [ND] = '{10, 1, 1, 2};
  localparam int VSW [ND] = '{2, 1, 1, 2};
  localparam int VB  [ND] = '{33, 1, 1, 3};
  localparam bit HPOL[ND] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit VPOL[ND] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int DIVS[ND] = '{2, 1, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic       pe0, a0, b0, hs0, vs0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pe1, a1, b1, hs1, vs1, ls1, fs1;
  logic [3:0] x1, y1;
  logic       pe2, a2, b2, hs2, vs2, ls2, fs2;
  logic [3:0] x2, y2;
  logic       pe3, a3, b3, hs3, vs3, ls3, fs3;
  logic [4:0] x3, y3;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HSW[0]), .H_BP(HB[0]),
                   .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VSW[0]), .V_BP(VB[0]),
                   .HS_POL(HPOL[0]), .VS_POL(VPOL[0]), .CLK_DIV(DIVS[0]), .CW(10)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe0), .x(x0), .y(y0), .active(a0), .blank(b0),
    .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(.H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HSW[1]), .H_BP(HB[1]),
                   .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VSW[1]), .V_BP(VB[1]),
                   .HS_POL(HPOL[1]), .VS_POL(VPOL[1]), .CLK_DIV(DIVS[1]), .CW(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe1), .x(x1), .y(y1), .active(a1), .blank(b1),
    .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(.H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HSW[2]), .H_BP(HB[2]),
                   .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VSW[2]), .V_BP(VB[2]),
                   .HS_POL(HPOL[2]), .VS_POL(VPOL[2]), .CLK_DIV(DIVS[2]), .CW(4)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe2), .x(x2), .y(y2), .active(a2), .blank(b2),
    .hsync(hs2), .vsync(vs2), .line_start(ls2), .frame_start(fs2));

  vga_timing_gen #(.H_ACTIVE(HA[3]), .H_FP(HF[3]), .H_SYNC(HSW[3]), .H_BP(HB[3]),
                   .V_ACTIVE(VA[3]), .V_FP(VF[3]), .V_SYNC(VSW[3]), .V_BP(VB[3]),
                   .HS_POL(HPOL[3]), .VS_POL(VPOL[3]), .CLK_DIV(DIVS[3]), .CW(5)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe3), .x(x3), .y(y3), .active(a3), .blank(b3),
    .hsync(hs3), .vsync(vs3), .line_start(ls3), .frame_start(fs3));

  int     checks = 0;
  int     errors = 0;
  longint n     [ND];   // enabled clks since the last reset
  bit     ls_e  [ND];
  bit     fs_e  [ND];
  longint cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_pos(input int d);
    longint ht = HA[d] + HF[d] + HSW[d] + HB[d];
    longint vt = VA[d] + VF[d] + VSW[d] + VB[d];
    return (n[d] / DIVS[d]) % (ht * vt);
  endfunction

  function automatic int model_x(input int d);
    return int'(model_pos(d) % (HA[d] + HF[d] + HSW[d] + HB[d]));
  endfunction

  task automatic model_edge(input bit r, input bit e);
    for (int d = 0; d < ND; d++) begin
      if (r) begin
        n[d] = 0; ls_e[d] = 0; fs_e[d] = 0;
      end else if (e) begin
        bit adv = (n[d] % DIVS[d]) == DIVS[d] - 1;
        n[d]++;
        ls_e[d] = adv && (model_x(d) == 0);
        fs_e[d] = adv && (model_pos(d) == 0);
      end else begin
        ls_e[d] = 0; fs_e[d] = 0;
      end
    end
  endtask

  task automatic check_pe(input int d, input logic ope);
    bit exp = en && !rst && ((n[d] % DIVS[d]) == DIVS[d] - 1);
    check($sformatf("d%0d.pix_en", d), 64'(ope), 64'(exp));
  endtask

  task automatic check_regs(input int d, input logic [63:0] ox, input logic [63:0] oy,
                            input logic oa, input logic ob, input logic ohs, input logic ovs,
                            input logic ols, input logic ofs);
    int  ht = HA[d] + HF[d] + HSW[d] + HB[d];
    int  ex = model_x(d);
    int  ey = int'(model_pos(d) / ht);
    bit  ea = (ex < HA[d]) && (ey < VA[d]);
    bit  in_hs = (ex >= HA[d] + HF[d]) && (ex < HA[d] + HF[d] + HSW[d]);
    bit  in_vs = (ey >= VA[d] + VF[d]) && (ey < VA[d] + VF[d] + VSW[d]);
    check($sformatf("d%0d.x", d), ox, 64'(ex));
    check($sformatf("d%0d.y", d), oy, 64'(ey));
    check($sformatf("d%0d.active", d), 64'(oa), 64'(ea));
    check($sformatf("d%0d.blank", d), 64'(ob), 64'(!ea));
    check($sformatf("d%0d.hsync", d), 64'(ohs), 64'(in_hs ? HPOL[d] : !HPOL[d]));
    check($sformatf("d%0d.vsync", d), 64'(ovs), 64'(in_vs ? VPOL[d] : !VPOL[d]));
    check($sformatf("d%0d.line_start", d), 64'(ols), 64'(ls_e[d]));
    check($sformatf("d%0d.frame_start", d), 64'(ofs), 64'(fs_e[d]));
  endtask

  task automatic step(input bit r, input bit e);
    rst = r;
    en  = e;
    #1;
    check_pe(0, pe0);
    check_pe(1, pe1);
    check_pe(2, pe2);
    check_pe(3, pe3);
    @(posedge clk);
    model_edge(r, e);
    cyc++;
    #1;
    check_regs(0, 64'(x0), 64'(y0), a0, b0, hs0, vs0, ls0, fs0);
    check_regs(1, 64'(x1), 64'(y1), a1, b1, hs1, vs1, ls1, fs1);
    check_regs(2, 64'(x2), 64'(y2), a2, b2, hs2, vs2, ls2, fs2);
    check_regs(3, 64'(x3), 64'(y3), a3, b3, hs3, vs3, ls3, fs3);
  endtask

  initial begin
    bit     found;
    longint last_ls0 = -1;
    longint last_fs3 = -1;
    for (int d = 0; d < ND; d++) begin
      n[d] = 0; ls_e[d] = 0; fs_e[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b1);

    // Free run: default line period 800*2 clks, medium frame period 32*13*3 clks.
    for (int i = 0; i < 4000; i++) begin
      step(1'b0, 1'b1);
      if (ls0) begin
        if (last_ls0 >= 0) check("d0.line_period", 64'(cyc - last_ls0), 64'd1600);
        last_ls0 = cyc;
      end
      if (fs3) begin
        if (last_fs3 >= 0) check("d3.frame_period", 64'(cyc - last_fs3), 64'd1248);
        last_fs3 = cyc;
      end
    end

    // Freeze the default raster at x=100 for 50 clks.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (model_x(0) == 100) found = 1;
      else step(1'b0, 1'b1);
    end
    check("reach_x100", 64'(found), 64'd1);
    repeat (50) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);

    // Reset in the horizontal blanking of the default raster.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (model_x(0) == 700) found = 1;
      else step(1'b0, 1'b1);
    end
    check("reach_x700", 64'(found), 64'd1);
    step(1'b1, 1'($urandom_range(0, 1)));
    repeat (10) step(1'b0, 1'b1);

    for (int i = 0; i < 36000; i++) begin
      step(1'($urandom_range(0, 19999) == 0), 1'($urandom_range(0, 9) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator producing pixel coordinates, active-video flag, sync pulses and line/frame strobes from the system clock via an internal pixel-rate enable. It replaces the fixed 640x480 sync block, sits between the board clock and the pixel/colour generation logic, and feeds the VGA output pins. The block adds configurable geometry, sync polarity and clock ratio, an enable input, and frame/line strobes. Coordinates and control outputs are mutually aligned.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- CLK_DIV, 2, clk cycles per pixel (≥1)
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes all state
- pix_en  out  1  one-clk strobe on the last clk of each pixel period
- x  out  CW  current horizontal position 0..H_TOTAL-1
- y  out  CW  current vertical position 0..V_TOTAL-1
- active  out  1  x<H_ACTIVE and y<V_ACTIVE
- blank  out  1  ~active
- hsync, vsync  out  1  sync outputs at configured polarity
- line_start  out  1  one-clk pulse when outputs advance to x=0
- frame_start  out  1  one-clk pulse when outputs advance to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider counts 0..CLK_DIV-1 while en=1. pix_en=1 exactly when divider = CLK_DIV-1 and en=1. With CLK_DIV=1, pix_en = en.
- On each pix_en, the pixel position advances:
  - h wraps H_TOTAL-1→0; on that wrap, v increments.
  - v wraps V_TOTAL-1→0 only on the h wrap. v never exceeds V_TOTAL-1 and h never exceeds H_TOTAL-1.
- Decode, all computed from the same (h,v):
  - hsync asserted iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. vsync changes only together with the h wrap.
  - Asserted sync level = HS_POL/VS_POL; deasserted = the inverse.
- All outputs except pix_en are registered and describe the same pixel. There is no skew between x/y and active/sync.
- line_start=1 for the single clk after the pix_en that moved h to 0. frame_start=1 likewise when (h,v) moved to (0,0). frame_start implies line_start.
- en=0: divider, counters and outputs hold; pix_en=0; strobes forced 0. Resuming continues from the held divider phase.
- rst=1 overrides en.
- Elaboration error if any porch/sync/active parameter is 0, CLK_DIV<1, or CW is too narrow.

## Timing
- Reset values (cycle after rst sampled high):
  - divider=0, x=0, y=0, active=1, blank=0
  - hsync=~HS_POL, vsync=~VS_POL
  - pix_en=0, line_start=0, frame_start=0
- Pixel (0,0) is held for CLK_DIV clks after reset release before the first advance. The first pix_en occurs CLK_DIV clks after rst deasserts, with en=1.
- Output latency: outputs change on the clk edge that samples pix_en=1; each pixel is held exactly CLK_DIV clks.
- Line period = H_TOTAL·CLK_DIV clks; frame period = H_TOTAL·V_TOTAL·CLK_DIV clks (default 840000).
- Reset mid-frame: the next cycle shows the reset values regardless of position or en.

## Structure
- Package vga_timing_pkg contains:
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL derivation
  - sync-region bound constants, shared with pixel generators
- Sub-module vga_pix_en: the CLK_DIV divider with en gating, outputting pix_en. The counters and decode live in vga_timing_gen.

## Test plan
- Defaults, en=1: frame_start pulses 840000 clks apart. hsync low for 192 clks starting when x=656. vsync low for exactly 2 lines starting at y=490, x=0. active low when x≥640 or y≥480.
- Tiny geometry (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1): x sequence 0..7 repeats; y 0..5. hsync asserted at x=5,6. vsync asserted at y=4. active for 12 pixels per frame.
- en=0 held 50 clks mid-line at x=100: x, y and all outputs frozen; pix_en=0. After release, x=101 appears after the remaining divider phase.
- rst pulsed at x=700, y=500: the next cycle shows x=0, y=0, active=1, sync deasserted. The first pix_en comes exactly CLK_DIV clks after release.
- HS_POL=1, VS_POL=1: sync outputs are the exact inverse of the default-polarity run. All other outputs are identical.
- CLK_DIV=3: pix_en is high one clk in three; line period is 2400 clks. line_start coincides with x=0 and never with pix_en gaps.
